oversample_data_sampler: RTL and testbench
==========================================

OVERSAMPLE_DATA_SAMPLER -- requirements
Module: oversample_data_sampler

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6: width of Prescale and edge_cnt.
REQ-002 SHALL have parameter NUM_SAMPLES, default 3: samples per bit, odd, legal range 1..7.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: RX_IN synchroniser depth, legal range 0..3.
REQ-004 SHALL have port CLK, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port data_sample_en, input, 1: sampling enable from the Rx FSM.
REQ-007 SHALL have port RX_IN, input, 1: serial line, idle high.
REQ-008 SHALL have port Prescale, input, PRESCALE_W: oversampling ratio (8, 16 or 32 in use).
REQ-009 SHALL have port edge_cnt, input, PRESCALE_W: oversample tick index within the current bit, 0..Prescale-1.
REQ-010 SHALL have port sampled_bit, output, 1: majority-voted bit value.
REQ-011 SHALL have port sample_valid, output, 1: one-cycle pulse marking a new sampled_bit.
REQ-012 SHALL have port noise_err, output, 1: samples of the last bit were not unanimous; valid with sample_valid.
REQ-013 SHALL have port cfg_err, output, 1: latched Prescale is unusable.

Function
REQ-014 SHALL pass RX_IN through SYNC_STAGES flops (reset value 1); all sampling SHALL use the synchronised value rx_s.
REQ-015 SHALL latch Prescale into p_lat on every cycle where edge_cnt==0 and the FSM is in IDLE or DONE; mid-bit Prescale changes SHALL NOT take effect.
REQ-016 SHALL compute the window start as ws = (p_lat>>1) - (NUM_SAMPLES-1)/2 and the window end as we = ws + NUM_SAMPLES - 1. Example: p_lat=8, N=3 gives ticks 3,4,5; p_lat=16, N=5 gives ticks 6..10.
REQ-017 SHALL assert cfg_err (registered) when p_lat < 2*NUM_SAMPLES; while cfg_err is high, no samples are taken and sample_valid stays 0.
REQ-018 SHALL implement an FSM with four states: IDLE, WAIT, COLLECT, DONE.
REQ-019 Transition IDLE->WAIT SHALL occur when data_sample_en=1 and edge_cnt < ws.
REQ-020 Transition WAIT->COLLECT SHALL occur on edge_cnt==ws; that cycle samples.
REQ-021 In COLLECT, each cycle with edge_cnt in [ws,we] SHALL add rx_s to a ones counter of width clog2(NUM_SAMPLES+1).
REQ-022 At edge_cnt==we, after the final add, the FSM SHALL go to DONE.
REQ-023 On the cycle after the final sample, sampled_bit SHALL equal (ones > NUM_SAMPLES/2), noise_err SHALL equal (ones != 0 && ones != NUM_SAMPLES), and sample_valid SHALL be 1 for exactly one cycle.
REQ-024 Transition DONE->WAIT SHALL occur on edge_cnt==0 with data_sample_en=1; the ones counter SHALL clear at that point; sampled_bit and noise_err SHALL hold until the next decision.
REQ-025 If data_sample_en falls in any state, the FSM SHALL go to IDLE next cycle, the ones counter SHALL clear, and no sample_valid SHALL be produced for the aborted bit.
REQ-026 If data_sample_en rises with edge_cnt >= ws (late enable), the FSM SHALL stay in IDLE until edge_cnt==0; no partial bit is voted.
REQ-027 Latency SHALL be: rx_s lags RX_IN by SYNC_STAGES cycles; sample_valid rises one cycle after the edge_cnt==we sample.

Reset
REQ-028 On RST low, the synchroniser flops SHALL reset to 1.
REQ-029 On RST low, FSM=IDLE, ones=0, p_lat=Prescale reset constant 8, sampled_bit=0, sample_valid=0, noise_err=0 and cfg_err=0.
REQ-030 Reset asserted mid-COLLECT SHALL discard the bit; after release, the block SHALL resume only via REQ-019/REQ-026.

Structure
REQ-031 State encodings and default parameter values SHALL live in CONFIG_MACROS.v.
REQ-032 The synchroniser SHALL be a sub-module rx_sync (parameter STAGES, reset value 1); SYNC_STAGES=0 SHALL be a wire-through.
REQ-033 The voter SHALL be count-based, not a fixed 3-input AND-OR tree, so that any odd NUM_SAMPLES works.

Verification
REQ-034 Scenario: N=3, p_lat=8, rx_s=1 at ticks 3,4,5 -> sampled_bit=1, noise_err=0, sample_valid pulse at tick 6.
REQ-035 Scenario: N=3, p_lat=8, rx_s=1,0,1 at ticks 3,4,5 -> sampled_bit=1, noise_err=1.
REQ-036 Scenario: N=5, p_lat=16, rx_s=0 at ticks 6,7,8 and 1 at ticks 9,10 -> sampled_bit=0, noise_err=1, valid at tick 11.
REQ-037 Scenario: data_sample_en dropped at tick 4 with p_lat=8 -> no sample_valid; next bit with all 0s -> sampled_bit=0, noise_err=0.
REQ-038 Scenario: Prescale changed 8->16 at tick 2 -> current bit still uses window 3..5; the next bit uses 7..9.
REQ-039 Scenario: N=5, Prescale=8 -> cfg_err=1 and no sample_valid over 4 bits; RST low mid-COLLECT -> all outputs return to REQ-029 values.

Source files
------------

// File: rtl/oversample_data_sampler_pkg.sv
// Shared state encoding and default configuration
// for the oversampling Rx data sampler.
package oversample_data_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_PRESCALE_W  = 6;
    localparam int DEF_NUM_SAMPLES = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int PRESCALE_RST    = 8;

endpackage

// File: rtl/oversample_data_sampler_rx_sync.sv
// Multi-flop synchroniser for the serial line,
// resetting to the idle-high level.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_wire
        assign q = d;
    end else begin : g_flops
        logic [STAGES-1:0] sync_q;
        logic [STAGES-1:0] sync_d;

        always_comb begin
            sync_d    = sync_q << 1;
            sync_d[0] = d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '1;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign q = sync_q[STAGES-1];
    end

endmodule

// File: rtl/oversample_data_sampler.sv
// Majority-vote sampler: takes NUM_SAMPLES oversample ticks
// centred in each bit and reports the voted value and noise.
module oversample_data_sampler
    import oversample_data_sampler_pkg::*;
#(
    parameter int PRESCALE_W  = DEF_PRESCALE_W,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  data_sample_en,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int ONES_W = $clog2(NUM_SAMPLES + 1);

    localparam logic [PRESCALE_W-1:0] P_RST =
        PRESCALE_W'(PRESCALE_RST);
    localparam logic [PRESCALE_W-1:0] P_MIN =
        PRESCALE_W'(2 * NUM_SAMPLES);
    localparam logic [PRESCALE_W-1:0] HALF_W =
        PRESCALE_W'((NUM_SAMPLES - 1) / 2);
    localparam logic [PRESCALE_W-1:0] SPAN =
        PRESCALE_W'(NUM_SAMPLES - 1);
    localparam logic [ONES_W-1:0] MAJ =
        ONES_W'(NUM_SAMPLES / 2);
    localparam logic [ONES_W-1:0] ALL_N =
        ONES_W'(NUM_SAMPLES);

    logic rx_s;

    rx_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .clk  (CLK),
        .rst_n(RST),
        .d    (RX_IN),
        .q    (rx_s)
    );

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] p_lat_q, p_lat_d;
    logic [ONES_W-1:0]     ones_q, ones_d;
    logic                  bit_q, bit_d;
    logic                  valid_q, valid_d;
    logic                  noise_q, noise_d;
    logic                  cfg_q, cfg_d;

    logic [PRESCALE_W-1:0] ws;
    logic [PRESCALE_W-1:0] we;
    logic [ONES_W-1:0]     ones_sum;
    logic                  cfg_bad;
    logic                  at_zero;
    logic                  at_ws;
    logic                  at_we;
    logic                  in_win;
    logic                  at_rest;
    logic                  take;
    logic                  last;

    always_comb begin
        ws       = (p_lat_q >> 1) - HALF_W;
        we       = ws + SPAN;
        cfg_bad  = p_lat_q < P_MIN;
        at_zero  = edge_cnt == '0;
        at_ws    = edge_cnt == ws;
        at_we    = edge_cnt == we;
        in_win   = (edge_cnt >= ws) && (edge_cnt <= we);
        at_rest  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        take     = data_sample_en && !cfg_bad &&
                   (((state_q == ST_WAIT) && at_ws) ||
                    ((state_q == ST_COLLECT) && in_win));
        last     = take && at_we;
        ones_sum = ones_q + ONES_W'(rx_s);
    end

    always_comb begin
        state_d = state_q;
        p_lat_d = p_lat_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        valid_d = 1'b0;
        cfg_d   = cfg_bad;

        // Prescale only moves between bits so a running window stays put
        if (at_rest && at_zero) begin
            p_lat_d = Prescale;
        end

        if (take) begin
            ones_d = ones_sum;
        end

        if (last) begin
            bit_d   = ones_sum > MAJ;
            noise_d = (ones_sum != '0) && (ones_sum != ALL_N);
            valid_d = 1'b1;
        end

        if (!data_sample_en || cfg_bad) begin
            state_d = ST_IDLE;
            ones_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (edge_cnt < ws) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else if (at_ws) begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (at_zero) begin
                        state_d = ST_WAIT;
                        ones_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            p_lat_q <= P_RST;
            ones_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            noise_q <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_lat_q <= p_lat_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            noise_q <= noise_d;
            cfg_q   <= cfg_d;
        end
    end

    assign sampled_bit  = bit_q;
    assign sample_valid = valid_q;
    assign noise_err    = noise_q;
    assign cfg_err      = cfg_q;

endmodule

// File: tb/tb_oversample_data_sampler.sv
// Bench for oversample_data_sampler: two instances (3 and 5
// samples per bit) share one stimulus stream.
module tb_oversample_data_sampler;

    localparam int PW = 6;
    localparam int HMASK = 8191;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          data_sample_en = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = 6'd8;
    logic [PW-1:0] edge_cnt = 6'd0;

    logic bit3, val3, nz3, cfg3;
    logic bit5, val5, nz5, cfg5;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic hist [0:HMASK];

    always #5 CLK = ~CLK;

    oversample_data_sampler #(
        .PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(2)
    ) dut3 (
        .CLK(CLK), .RST(RST),
        .data_sample_en(data_sample_en), .RX_IN(RX_IN),
        .Prescale(Prescale), .edge_cnt(edge_cnt),
        .sampled_bit(bit3), .sample_valid(val3),
        .noise_err(nz3), .cfg_err(cfg3)
    );

    oversample_data_sampler #(
        .PRESCALE_W(PW), .NUM_SAMPLES(5), .SYNC_STAGES(2)
    ) dut5 (
        .CLK(CLK), .RST(RST),
        .data_sample_en(data_sample_en), .RX_IN(RX_IN),
        .Prescale(Prescale), .edge_cnt(edge_cnt),
        .sampled_bit(bit5), .sample_valid(val5),
        .noise_err(nz5), .cfg_err(cfg5)
    );

    typedef struct {
        logic en;
        logic rx;
        int   ec;
        int   pre;
        logic v3;
        logic b3;
        logic n3;
        logic bn;
        logic v5;
        logic c5;
    } vec_t;

    vec_t tbl[$];
    vec_t row;
    logic [2:0] pats [4];
    logic [2:0] pv;
    logic exp_b [4];
    logic exp_n [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // apply inputs for one cycle, then wait to the sampling edge
    task automatic drive(input logic en_i, input logic rx_i,
                         input int ec, input int pre);
        data_sample_en = en_i;
        RX_IN          = rx_i;
        edge_cnt       = PW'(ec);
        Prescale       = PW'(pre);
        hist[cyc & HMASK] = rx_i;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic rxs(input int c);
        if (c < 2) return 1'b1;
        return hist[(c - 2) & HMASK];
    endfunction

    function automatic int pick_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 0, 8);
            adv();
        end
    endtask

    task automatic hbit(input string tag, input int p0, input int p1,
                        input int len, input int t0,
                        input int start, input int stop,
                        input logic [31:0] rxv,
                        input int vt3, input logic eb3, input logic ez3,
                        input int vt5, input logic eb5, input logic ez5);
        logic [31:0] rv;
        rv = rxv;
        for (int t = t0; t < len; t++) begin
            drive((t >= start) && (t < stop), rv[t], t,
                  (t < 2) ? p0 : p1);
            chk({tag, "_v3"}, val3, t == vt3);
            chk({tag, "_v5"}, val5, t == vt5);
            if (t == vt3) begin
                chk({tag, "_bit3"}, bit3, eb3);
                chk({tag, "_nz3"}, nz3, ez3);
            end
            if (t == vt5) begin
                chk({tag, "_bit5"}, bit5, eb5);
                chk({tag, "_nz5"}, nz5, ez5);
            end
            adv();
        end
    endtask

    task automatic rand_test(input int nbits);
        int   nn [2];
        int   ws [2];
        int   we [2];
        int   ones [2];
        logic ok [2];
        int   p, start, stop, c;
        logic base, rx, rs, v, b, z, cf;
        nn[0] = 3;
        nn[1] = 5;
        for (int k = 0; k < nbits; k++) begin
            p = pick_p();
            start = 0;
            stop = p;
            if ($urandom_range(0, 3) == 0) start = $urandom_range(0, p - 1);
            if ($urandom_range(0, 3) == 0) stop = $urandom_range(start + 1, p);
            base = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                ws[i]   = p / 2 - (nn[i] - 1) / 2;
                we[i]   = ws[i] + nn[i] - 1;
                ones[i] = 0;
                ok[i]   = (p >= 2 * nn[i]) && (start < ws[i]) &&
                          (stop > we[i]);
            end
            for (int t = 0; t < p; t++) begin
                rx = ($urandom_range(0, 3) == 0) ? ~base : base;
                drive((t >= start) && (t < stop), rx, t,
                      (t == 0) ? p : pick_p());
                c  = cyc - 1;
                rs = rxs(c);
                for (int i = 0; i < 2; i++) begin
                    v  = (i == 0) ? val3 : val5;
                    b  = (i == 0) ? bit3 : bit5;
                    z  = (i == 0) ? nz3 : nz5;
                    cf = (i == 0) ? cfg3 : cfg5;
                    if ((t >= ws[i]) && (t <= we[i])) ones[i] += int'(rs);
                    chk("rnd_valid", v, ok[i] && (t == we[i] + 1));
                    if (ok[i] && (t == we[i] + 1)) begin
                        chk("rnd_bit", b, ones[i] > nn[i] / 2);
                        chk("rnd_noise", z,
                            (ones[i] != 0) && (ones[i] != nn[i]));
                    end
                    if (t >= 2) chk("rnd_cfg", cf, p < 2 * nn[i]);
                end
                adv();
            end
        end
    endtask

    initial begin
        pats[0] = 3'b111; exp_b[0] = 1'b1; exp_n[0] = 1'b0;
        pats[1] = 3'b101; exp_b[1] = 1'b1; exp_n[1] = 1'b1;
        pats[2] = 3'b000; exp_b[2] = 1'b0; exp_n[2] = 1'b0;
        pats[3] = 3'b100; exp_b[3] = 1'b0; exp_n[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pv = pats[i];
            for (int t = 0; t < 8; t++) begin
                row.en  = 1'b1;
                row.rx  = ((t >= 1) && (t <= 3)) ? pv[3-t] : 1'b1;
                row.ec  = t;
                row.pre = 8;
                row.v3  = (t == 6);
                row.b3  = exp_b[i];
                row.n3  = exp_n[i];
                row.bn  = (t >= 6);
                row.v5  = 1'b0;
                row.c5  = 1'b1;
                tbl.push_back(row);
            end
        end

        #2 RST = 1'b0;
        drive(1'b0, 1'b1, 0, 16);
        chk("rst_bit3", bit3, 1'b0);
        chk("rst_val3", val3, 1'b0);
        chk("rst_nz3", nz3, 1'b0);
        chk("rst_cfg3", cfg3, 1'b0);
        chk("rst_val5", val5, 1'b0);
        chk("rst_cfg5", cfg5, 1'b0);
        adv();
        RST = 1'b1;
        idle(4);
        drive(1'b0, 1'b1, 0, 8);
        chk("idle_cfg3", cfg3, 1'b0);
        chk("idle_cfg5", cfg5, 1'b1);
        chk("idle_val3", val3, 1'b0);
        adv();

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].rx, tbl[i].ec, tbl[i].pre);
            chk("tbl_v3", val3, tbl[i].v3);
            if (tbl[i].bn) begin
                chk("tbl_bit3", bit3, tbl[i].b3);
                chk("tbl_nz3", nz3, tbl[i].n3);
            end
            chk("tbl_v5", val5, tbl[i].v5);
            chk("tbl_cfg5", cfg5, tbl[i].c5);
            chk("tbl_cfg3", cfg3, 1'b0);
            adv();
        end

        hbit("p16", 16, 16, 16, 0, 0, 16, 32'hFFFF_FF8F,
             10, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        hbit("abort", 8, 8, 8, 0, 0, 4, 32'hFFFF_FFFF,
             -1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        hbit("zeros", 8, 8, 8, 0, 0, 8, 32'hFFFF_FFF1,
             6, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        hbit("late", 8, 8, 8, 0, 4, 8, 32'hFFFF_FFFF,
             -1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        hbit("resume", 8, 8, 8, 0, 0, 8, 32'hFFFF_FFFF,
             6, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        hbit("pchg", 8, 16, 8, 0, 0, 8, 32'h0000_000E,
             6, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        hbit("pnext", 16, 16, 16, 0, 0, 16, 32'h0000_00E0,
             10, 1'b1, 1'b0, 11, 1'b1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            drive(1'b1, 1'b1, t, 16);
            adv();
        end
        drive(1'b1, 1'b1, 8, 16);
        RST = 1'b0;
        #1;
        chk("mid_bit3", bit3, 1'b0);
        chk("mid_nz3", nz3, 1'b0);
        chk("mid_val3", val3, 1'b0);
        chk("mid_cfg3", cfg3, 1'b0);
        chk("mid_bit5", bit5, 1'b0);
        chk("mid_nz5", nz5, 1'b0);
        chk("mid_val5", val5, 1'b0);
        chk("mid_cfg5", cfg5, 1'b0);
        adv();
        drive(1'b1, 1'b1, 9, 16);
        adv();
        RST = 1'b1;
        hbit("postrst", 16, 16, 8, 1, 0, 8, 32'hFFFF_FFFF,
             6, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 0, 8);
        chk("post_cfg5", cfg5, 1'b1);
        chk("post_cfg3", cfg3, 1'b0);
        adv();

        rand_test(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
